reg_file: RTL and testbench
===========================

# reg_file

Parametrised general-purpose register file for the CPU datapath, replacing the external 16×16 register bank plus its combinational read/decode multiplexer. It holds NUM_REGS registers of DATA_W bits and provides:
- one synchronous write port with a one-hot enable readback;
- two combinational operand read ports (destination and source operands);
- one registered debug read port.

A clear sequencer zeroes the whole file one register per cycle on request.

## Interface
Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 16, number of registers; 2..256, power of two not required.
- ADDR_W, derived localparam = $clog2(NUM_REGS), not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- dest_reg  in  ADDR_W  destination operand address; read port dr and write address.
- sour_reg  in  ADDR_W  source operand address; read port sr.
- reg_sel  in  ADDR_W  debug read address.
- wr_en  in  1  write request for dest_reg this cycle.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  start clear sweep; level sampled in IDLE only.
- dr  out  DATA_W  contents of register dest_reg (combinational).
- sr  out  DATA_W  contents of register sour_reg (combinational).
- reg_out  out  DATA_W  contents of register reg_sel, registered.
- wr_onehot  out  NUM_REGS  one-hot strobe of the write actually accepted this cycle (combinational).
- busy  out  1  high while clear sweep in progress.
- wr_drop  out  1  one-cycle pulse: a write was rejected in the previous cycle.

## Operation
- Storage: NUM_REGS × DATA_W flops, all reset to 0.
- Write acceptance:
  - A write is accepted when wr_en=1, state=IDLE and dest_reg<NUM_REGS.
  - An accepted write stores wr_data into reg[dest_reg] at the clock edge.
  - wr_onehot has bit dest_reg set when a write is accepted; otherwise it is all zero.
- Write rejection:
  - A write is rejected when wr_en=1 and either state=CLEAR or dest_reg≥NUM_REGS.
  - Nothing is stored.
  - wr_drop=1 in the following cycle.
- Reads:
  - dr = reg[dest_reg]; sr = reg[sour_reg].
  - Any address ≥NUM_REGS reads as 0.
- Debug port: reg_out is loaded with reg[reg_sel] (or 0 if out of range) every cycle.
- FSM states:
  - IDLE:
    - clr_req=1 → CLEAR with cnt=0.
    - A write in the same cycle as clr_req is still accepted; the sweep erases it later.
  - CLEAR:
    - Each cycle, reg[cnt]←0 and cnt←cnt+1.
    - When cnt=NUM_REGS-1, the last register is cleared and the FSM returns to IDLE.
    - clr_req is ignored while in CLEAR.
    - busy=1 throughout CLEAR.
- Reads during CLEAR return current storage, so already-swept registers read as 0.
- cnt width: ADDR_W; it never wraps past NUM_REGS-1.

## Timing
- Reset values while rst_n=0: all registers 0, state IDLE, cnt 0, busy 0, wr_drop 0, reg_out 0.
  - dr, sr and wr_onehot are combinational; after reset they reflect zeroed storage and current inputs.
- Write-to-read latency:
  - Without bypass: dr/sr show new data in the cycle after the write edge.
  - reg_out shows new data two cycles after the write edge.
- Debug latency: 1 cycle from reg_sel to reg_out.
- Clear duration: exactly NUM_REGS cycles.
  - busy rises in the cycle after clr_req is sampled.
  - busy falls after NUM_REGS cycles high.
  - The first write after the sweep can be accepted in the cycle busy is low.
- Reset asserted mid-sweep: immediate return to IDLE with all outputs at reset values; no partial state retained.

## Configuration
- REG_FILE_BYPASS_EN:
  - Defined: when a write is accepted and a read address equals dest_reg, dr/sr return wr_data in the same cycle.
    - Since dr always reads dest_reg, dr bypasses on every accepted write.
    - reg_out is never bypassed.
  - Undefined: dr/sr always return stored contents; no write-to-read path exists.

## Structure
- Package reg_file_pkg holds:
  - the state enum (ST_IDLE, ST_CLEAR);
  - the defaults DATA_W_DEF=16 and NUM_REGS_DEF=16.
- Sub-module reg_file_clear_fsm (state, cnt, busy, and clear strobe/index outputs). Storage, decode and read muxes stay in reg_file.

## Test plan
- Reset, then write 0x1234 to r3 and 0xBEEF to r15 → next cycle sr(sour_reg=3)=0x1234, dr(dest_reg=15)=0xBEEF; wr_onehot=0x0008 during the r3 write.
- With REG_FILE_BYPASS_EN: wr_en=1, dest_reg=5, wr_data=0xA5A5, sour_reg=5 → sr=0xA5A5 in the same cycle. Without the macro → sr=old value that cycle, 0xA5A5 the next.
- Fill all 16 registers, pulse clr_req → busy high for exactly 16 cycles; reg[i] reads 0 from sweep cycle i+1 onward.
- Write r2 during CLEAR → r2 stays 0; wr_drop=1 in the next cycle; wr_onehot=0.
- NUM_REGS=12: write to address 13 → dropped, wr_drop pulses; read of address 13 returns 0.
- Assert rst_n=0 at sweep cycle 7 → busy=0 and all registers read 0 immediately; clr_req after release restarts the sweep at cnt=0.

Source files
------------

// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_file_pkg
// Brief  : Shared state encoding and parameter defaults for the register file.
// Rev    : 1.0  initial release
// ============================================================================
package reg_file_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 16;

endpackage
`default_nettype wire

// File: rtl/reg_file_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module : reg_file_clear_fsm
// Brief  : Clear sequencer; sweeps one register index per cycle while busy.
// Rev    : 1.0  initial release
// ============================================================================
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr_req,
  output logic              o_busy,
  output logic              o_clr_stb,
  output logic [ADDR_W-1:0] o_clr_idx
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_REGS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_busy      = 1'b0;
    o_clr_stb   = 1'b0;
    o_clr_idx   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        o_busy    = 1'b1;
        o_clr_stb = 1'b1;
        // Stop on the last index so the counter never wraps past NUM_REGS-1.
        if (r_cnt == c_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module : reg_file
// Brief  : NUM_REGS x DATA_W register file, 1 write / 2 comb reads / 1 debug
//          registered read, with sequential clear. Optional write-to-read
//          bypass enabled by defining REG_FILE_BYPASS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   dest_reg,
  input  logic [ADDR_W-1:0]   sour_reg,
  input  logic [ADDR_W-1:0]   reg_sel,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                clr_req,
  output logic [DATA_W-1:0]   dr,
  output logic [DATA_W-1:0]   sr,
  output logic [DATA_W-1:0]   reg_out,
  output logic [NUM_REGS-1:0] wr_onehot,
  output logic                busy,
  output logic                wr_drop
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [DATA_W-1:0] r_reg_out;
  logic              r_wr_drop;

  logic              w_clr_stb;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_dest_ok;
  logic              w_sour_ok;
  logic              w_sel_ok;
  logic              w_wr_acc;
  logic              w_wr_rej;
  logic [DATA_W-1:0] w_dr_mem;
  logic [DATA_W-1:0] w_sr_mem;
  logic [DATA_W-1:0] w_dbg;

  reg_file_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clr_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr_req (clr_req),
    .o_busy    (busy),
    .o_clr_stb (w_clr_stb),
    .o_clr_idx (w_clr_idx)
  );

  // Address range checks matter only when NUM_REGS is not a power of two.
  assign w_dest_ok = 32'(dest_reg) < NUM_REGS;
  assign w_sour_ok = 32'(sour_reg) < NUM_REGS;
  assign w_sel_ok  = 32'(reg_sel)  < NUM_REGS;

  assign w_wr_acc = wr_en && !busy && w_dest_ok;
  assign w_wr_rej = wr_en && !w_wr_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_clr_stb) begin
      r_regs[w_clr_idx] <= '0;
    end else if (w_wr_acc) begin
      r_regs[dest_reg] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
    assign wr_onehot[gi] = w_wr_acc && (dest_reg == ADDR_W'(gi));
  end

  assign w_dr_mem = w_dest_ok ? r_regs[dest_reg] : '0;
  assign w_sr_mem = w_sour_ok ? r_regs[sour_reg] : '0;
  assign w_dbg    = w_sel_ok  ? r_regs[reg_sel]  : '0;

`ifdef REG_FILE_BYPASS_EN
  assign dr = w_wr_acc ? wr_data : w_dr_mem;
  assign sr = (w_wr_acc && (sour_reg == dest_reg)) ? wr_data : w_sr_mem;
`else
  assign dr = w_dr_mem;
  assign sr = w_sr_mem;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg_out <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_reg_out <= w_dbg;
      r_wr_drop <= w_wr_rej;
    end
  end

  assign reg_out = r_reg_out;
  assign wr_drop = r_wr_drop;

endmodule
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// tb_reg_file: table vectors, directed sweep/reset sequences and random
// traffic checked against an array-based model of the register file.
module tb_reg_file;

  localparam int DW  = 16;
  localparam int N   = 16;
  localparam int AW  = 4;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] dest_reg = '0, sour_reg = '0, reg_sel = '0;
  logic          wr_en = 1'b0, clr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] dr, sr, reg_out;
  logic [N-1:0]  wr_onehot;
  logic          busy, wr_drop;

  logic [AW-1:0] b_dest = '0, b_sour = '0, b_sel = '0;
  logic          b_wr_en = 1'b0, b_clr = 1'b0;
  logic [DW-1:0] b_data = '0;
  logic [DW-1:0] b_dr, b_sr, b_ro;
  logic [11:0]   b_oh;
  logic          b_busy, b_drop;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst_n(rst_n), .dest_reg(dest_reg), .sour_reg(sour_reg),
    .reg_sel(reg_sel), .wr_en(wr_en), .wr_data(wr_data), .clr_req(clr_req),
    .dr(dr), .sr(sr), .reg_out(reg_out), .wr_onehot(wr_onehot),
    .busy(busy), .wr_drop(wr_drop)
  );

  reg_file #(.DATA_W(16), .NUM_REGS(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .dest_reg(b_dest), .sour_reg(b_sour),
    .reg_sel(b_sel), .wr_en(b_wr_en), .wr_data(b_data), .clr_req(b_clr),
    .dr(b_dr), .sr(b_sr), .reg_out(b_ro), .wr_onehot(b_oh),
    .busy(b_busy), .wr_drop(b_drop)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Behavioural model: storage array plus remaining-sweep-cycles counter.
  logic [DW-1:0] m_regs [N];
  int            m_left;
  int            m_idx;
  logic          m_drop;
  logic [DW-1:0] m_regout;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] dest;
    logic [AW-1:0] sour;
    logic [AW-1:0] sel;
    logic [DW-1:0] data;
    logic [DW-1:0] e_dr;
    logic [DW-1:0] e_sr;
    logic [DW-1:0] e_oh;
    logic [DW-1:0] e_ro;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_left = 0; m_idx = 0; m_drop = 1'b0; m_regout = '0;
  endtask

  task automatic model_check();
    bit            acc;
    logic [DW-1:0] e_dr, e_sr;
    acc  = wr_en && (m_left == 0);
    e_dr = (BYP && acc) ? wr_data : m_regs[dest_reg];
    e_sr = (BYP && acc && (sour_reg == dest_reg)) ? wr_data : m_regs[sour_reg];
    check("m_dr", dr, e_dr);
    check("m_sr", sr, e_sr);
    check("m_wr_onehot", wr_onehot, acc ? (32'd1 << dest_reg) : 32'd0);
    check("m_busy", busy, m_left > 0);
    check("m_wr_drop", wr_drop, m_drop);
    check("m_reg_out", reg_out, m_regout);
  endtask

  task automatic settle();
    @(negedge clk);
    model_check();
  endtask

  task automatic tick();
    bit acc;
    @(posedge clk);
    acc      = wr_en && (m_left == 0);
    m_regout = m_regs[reg_sel];
    m_drop   = wr_en && !acc;
    if (acc) m_regs[dest_reg] = wr_data;
    if (m_left > 0) begin
      m_regs[m_idx] = '0;
      m_idx++;
      m_left--;
    end else if (clr_req) begin
      m_left = N;
      m_idx  = 0;
    end
    #1;
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) begin
      wr_en = 1'b1; dest_reg = AW'(i); wr_data = base + DW'(i);
      settle(); tick();
    end
    wr_en = 1'b0;
  endtask

  // Pulse clr_req, then count busy cycles; probe swept registers and a write during the sweep.
  task automatic run_sweep(output int nb);
    bit done;
    nb = 0; done = 1'b0;
    clr_req = 1'b1; settle(); tick(); clr_req = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      sour_reg = (nb >= 1) ? AW'(nb - 1) : '0;
      wr_en    = (nb == 3);
      dest_reg = 4'd2;
      wr_data  = 16'hDEAD;
      settle();
      if (busy) begin
        if (nb == 3) check("clr_wr_onehot", wr_onehot, 0);
        if (nb == 4) check("clr_wr_drop", wr_drop, 1);
        if (nb >= 1) check($sformatf("sweep%0d_read0", nb), sr, 0);
        nb++;
      end else if (nb > 0) begin
        done = 1'b1;
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    model_reset();

    tbl[0] = '{1'b1, 4'd3,  4'd3,  4'd0,  16'h1234, BYP ? 16'h1234 : 16'h0, BYP ? 16'h1234 : 16'h0, 16'h0008, 16'h0};
    tbl[1] = '{1'b1, 4'd15, 4'd3,  4'd0,  16'hBEEF, BYP ? 16'hBEEF : 16'h0, 16'h1234, 16'h8000, 16'h0};
    tbl[2] = '{1'b0, 4'd15, 4'd3,  4'd3,  16'h0,    16'hBEEF, 16'h1234, 16'h0, 16'h0};
    tbl[3] = '{1'b0, 4'd3,  4'd15, 4'd15, 16'h0,    16'h1234, 16'hBEEF, 16'h0, 16'h1234};
    tbl[4] = '{1'b1, 4'd5,  4'd5,  4'd5,  16'hA5A5, BYP ? 16'hA5A5 : 16'h0, BYP ? 16'hA5A5 : 16'h0, 16'h0020, 16'hBEEF};
    tbl[5] = '{1'b0, 4'd0,  4'd5,  4'd5,  16'h0,    16'h0,    16'hA5A5, 16'h0, 16'h0};
    tbl[6] = '{1'b0, 4'd0,  4'd0,  4'd0,  16'h0,    16'h0,    16'h0,    16'h0, 16'hA5A5};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_wr_drop", wr_drop, 0);
    check("rst_reg_out", reg_out, 0);
    check("rst_dr", dr, 0);
    check("rst_sr", sr, 0);
    check("rst_onehot", wr_onehot, 0);
    check("rst12_busy", b_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      wr_en = tbl[i].we; dest_reg = tbl[i].dest; sour_reg = tbl[i].sour;
      reg_sel = tbl[i].sel; wr_data = tbl[i].data; clr_req = 1'b0;
      settle();
      check($sformatf("vec%0d_dr", i), dr, tbl[i].e_dr);
      check($sformatf("vec%0d_sr", i), sr, tbl[i].e_sr);
      check($sformatf("vec%0d_onehot", i), wr_onehot, tbl[i].e_oh);
      check($sformatf("vec%0d_reg_out", i), reg_out, tbl[i].e_ro);
      tick();
    end

    // Non-power-of-two instance: out-of-range write and read.
    b_wr_en = 1'b1; b_dest = 4'd13; b_data = 16'h7777; b_sour = 4'd13;
    settle();
    check("n12_wr13_onehot", b_oh, 0);
    check("n12_dr13", b_dr, 0);
    check("n12_sr13", b_sr, 0);
    tick();
    b_wr_en = 1'b0; b_dest = 4'd11;
    settle();
    check("n12_wr_drop", b_drop, 1);
    tick();
    b_wr_en = 1'b1; b_dest = 4'd11; b_data = 16'h1111;
    settle();
    check("n12_wr11_onehot", b_oh, 12'h800);
    tick();
    b_wr_en = 1'b0; b_sour = 4'd11;
    settle();
    check("n12_no_drop", b_drop, 0);
    check("n12_sr11", b_sr, 16'h1111);
    b_sour = 4'd13; #1;
    check("n12_sr13_after", b_sr, 0);
    tick();

    fill(16'h0100);
    run_sweep(nb);
    check("clear_busy_cycles", nb, N);
    sour_reg = 4'd2;
    settle();
    check("r2_after_drop", sr, 0);
    tick();

    for (int c = 0; c < 400; c++) begin
      wr_en    = ($urandom_range(0, 3) != 0);
      dest_reg = AW'($urandom);
      sour_reg = ($urandom_range(0, 3) == 0) ? dest_reg : AW'($urandom);
      reg_sel  = AW'($urandom);
      wr_data  = DW'($urandom);
      clr_req  = ($urandom_range(0, 59) == 0);
      settle(); tick();
    end
    wr_en = 1'b0; clr_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      settle(); tick();
    end

    // Reset in sweep cycle 7, then restart the sweep from index 0.
    fill(16'h0F00);
    clr_req = 1'b1; settle(); tick(); clr_req = 1'b0;
    repeat (7) begin
      settle(); tick();
    end
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_wr_drop", wr_drop, 0);
    check("midrst_reg_out", reg_out, 0);
    for (int a = 0; a < N; a++) begin
      sour_reg = AW'(a); dest_reg = AW'(a); #1;
      check($sformatf("midrst_sr%0d", a), sr, 0);
      check($sformatf("midrst_dr%0d", a), dr, 0);
    end
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    fill(16'h0A00);
    run_sweep(nb);
    check("restart_busy_cycles", nb, N);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
